// File: rtl/serial_mag_comparator_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cmp_state_t;

  // Number of digits evaluated per compare.
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit index register width: $clog2(NDIG), never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Request/result bundle for the serial magnitude comparator.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, lt, gt, eq
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, lt, gt, eq
  );
endinterface

// File: rtl/serial_mag_comparator_digit_cell.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module cmp_digit_cell #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             dlt,
  output logic             dgt,
  output logic             deq
);

  // Plain unsigned relation of the two slices.
  always_comb begin
    dlt = (a < b);
    dgt = (a > b);
    deq = (a == b);
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock.
// Optional build macro: CMP_EARLY_EXIT_EN -- finish on the first differing digit
// instead of always walking all NDIG digits.
//
// state | meaning
// IDLE  | no compare in progress; start is accepted
// RUN   | evaluating digit [idx], one digit per clock
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_mag_comparator_if.slave  bus
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int IW   = idx_width(NDIG);

  if ((WIDTH % DIGIT) != 0) begin : g_width_check
    $error("serial_mag_comparator: WIDTH must be a multiple of DIGIT");
  end

  cmp_state_t       state;
  cmp_state_t       state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic             decided;
  logic             dlt_r;
  logic             dgt_r;
  logic             busy_r;
  logic             done_r;
  logic             lt_r;
  logic             gt_r;
  logic             eq_r;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             cell_lt;
  logic             cell_gt;
  logic             cell_eq;
  logic             accept;
  logic             finish;
  logic             cur_lt;
  logic             cur_gt;
  logic [WIDTH-1:0] msb_flip;

  // Select the digit currently pointed at by idx.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        a_dig = a_r[i*DIGIT +: DIGIT];
        b_dig = b_r[i*DIGIT +: DIGIT];
      end
    end
  end

  cmp_digit_cell #(.DIGIT(DIGIT)) u_cell (
    .a   (a_dig),
    .b   (b_dig),
    .dlt (cell_lt),
    .dgt (cell_gt),
    .deq (cell_eq)
  );

  // Verdict so far including the digit under evaluation; earlier decisions win.
  always_comb begin
    cur_lt   = decided ? dlt_r : cell_lt;
    cur_gt   = decided ? dgt_r : cell_gt;
    accept   = (state == IDLE) && bus.start;
    msb_flip = {bus.signed_mode, {(WIDTH-1){1'b0}}};
`ifdef CMP_EARLY_EXIT_EN
    finish   = (state == RUN) && ((idx == '0) || (!decided && !cell_eq));
`else
    finish   = (state == RUN) && (idx == '0);
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, digit walk and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      dlt_r   <= 1'b0;
      dgt_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      lt_r    <= 1'b0;
      gt_r    <= 1'b0;
      eq_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        // Flipping both MSBs maps two's complement onto offset binary,
        // so the digit walk is always an unsigned compare.
        a_r     <= bus.a ^ msb_flip;
        b_r     <= bus.b ^ msb_flip;
        idx     <= IW'(NDIG - 1);
        decided <= 1'b0;
        dlt_r   <= 1'b0;
        dgt_r   <= 1'b0;
        busy_r  <= 1'b1;
        lt_r    <= 1'b0;
        gt_r    <= 1'b0;
        eq_r    <= 1'b0;
      end else if (state == RUN) begin
        if (!decided && !cell_eq) begin
          decided <= 1'b1;
          dlt_r   <= cell_lt;
          dgt_r   <= cell_gt;
        end
        idx <= idx - 1'b1;
        if (finish) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          lt_r   <= cur_lt;
          gt_r   <= cur_gt;
          eq_r   <= !(cur_lt || cur_gt);
        end
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.lt   = lt_r;
  assign bus.gt   = gt_r;
  assign bus.eq   = eq_r;

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. Successor to the team's fixed 2-bit gate-level comparator.
- Compares DIGIT bits per clock, MSB-first, using a start/busy/done handshake.
- Supports an unsigned or two's-complement mode per operation.
- Sits beside datapath blocks that need lt/gt/eq flags, and trades latency for area on wide operands.

Parameters:
- WIDTH, 8, operand width in bits; must be an integer multiple of DIGIT (elaboration error otherwise).
- DIGIT, 2, bits compared per clock; NDIG = WIDTH/DIGIT digits per operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a compare; accepted only when busy=0.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  in  WIDTH  operand A; sampled on the accepting edge.
- b  in  WIDTH  operand B; sampled on the accepting edge.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-clock pulse: result is valid.
- lt  out  1  A < B.
- gt  out  1  A > B.
- eq  out  1  A == B.

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, lt=0, gt=0, eq=0, internal operand, index and decided registers cleared.
- Reset asserted mid-operation aborts the compare immediately. No done pulse follows.
- FSM states:
  - IDLE: idle, no compare in progress.
  - RUN: compare in progress.
- Transitions:
  - IDLE -> RUN on start=1 at a rising edge.
  - RUN -> IDLE after the last digit is evaluated.
  - During the done cycle the state is already IDLE, so start is accepted then (back-to-back operation).
- On the accepting edge:
  - Capture a, b and signed_mode.
  - If signed_mode=1, invert the MSB of both captured operands (offset-binary). The remaining compare is always unsigned.
  - Set index=NDIG-1, decided=0, busy=1.
  - Clear lt, gt and eq.
- Each RUN cycle:
  - The digit cell compares a_digit[index] and b_digit[index].
  - If decided=0 and the digits differ, set decided=1 and latch the sign of the difference (dlt/dgt).
  - index decrements.
  - Digits below the deciding digit are ignored.
- Completion (without the optional feature): on the edge that evaluates digit 0:
  - busy falls to 0.
  - done rises for exactly one clock.
  - lt/gt/eq are loaded; eq=1 only if decided=0.
  - Latency: done is high NDIG clocks after the accepting edge (4 for the defaults).
- Exactly one of lt/gt/eq is 1 while a result is valid.
- Results are held until the next accepted start.
- start while busy=1 is ignored. Changes on a, b or signed_mode while busy=1 have no effect.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: the compare terminates on the edge that evaluates the first differing digit. busy falls, done pulses and the result loads, so latency = NDIG - index_of_first_difference clocks. Equal operands still take NDIG clocks.
- Undefined: fixed NDIG-clock latency regardless of the operand data.

Decomposition:
- Package cmp_pkg holds:
  - state enum cmp_state_t (IDLE, RUN).
  - function ndig(WIDTH, DIGIT).
  - localparam width rule for index: $clog2(NDIG), minimum 1 bit.
- One natural sub-module: cmp_digit_cell, a combinational DIGIT-bit compare producing dlt/dgt/deq. It is instantiated once and muxed by index.

Test Plan (WIDTH=8, DIGIT=2):
- Equal operands: a=0x5A, b=0x5A, unsigned, start pulse -> done 4 clocks later; eq=1, lt=0, gt=0; busy high for 4 clocks.
- Mode-dependent result: a=0x80, b=0x7F -> unsigned gives gt=1; signed gives lt=1.
- Low-digit difference: a=0x03, b=0x02 -> gt=1 after 4 clocks. With CMP_EARLY_EXIT_EN, a=0xC0, b=0x40 -> gt=1 with done 1 clock after start.
- Start while busy: start held high, with a/b changed to 0x00/0xFF during busy -> first result unaffected (a=0x10, b=0x20 gives lt=1). A second compare is accepted in the done cycle and completes 4 clocks later.
- Reset mid-operation: rst_n low in clock 2 of a compare -> busy=0, done=0, lt/gt/eq=0 immediately; no done pulse follows; next start works normally.
- Result hold: after done, idle for 10 clocks -> lt/gt/eq unchanged; cleared on the next accepted start.
